// File: rtl/shreg_univ_if.sv
// Bus bundle for the universal shift register: command/data inputs plus
// register contents and handshake outputs. Clock and reset stay outside.
interface shreg_univ_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic [2:0]       op;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sr_in;
    logic             sl_in;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    // Controller side: issues commands, observes the register
    modport master (
        output op, start, amt, d, sr_in, sl_in,
        input  q, sout, busy, done
    );

    // Register side
    modport slave (
        input  op, start, amt, d, sr_in, sl_in,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shreg_univ.sv
// Parametrised universal shift register with single-step operations and a
// multi-cycle "shift by N" command (start/busy/done handshake).
module shreg_univ #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    shreg_univ_if.slave   bus
);
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             sout_reg, sout_next;
    logic             done_reg, done_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;   // steps still to execute after the current one
    logic [2:0]       op_reg, op_next;     // operation captured at start

    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic             is_multi;

    // Bit-level shift networks: down_v moves every bit one place toward the
    // LSB, up_v one place toward the MSB. The vacated end bit is filled per op.
    logic [WIDTH-1:0] down_v;
    logic [WIDTH-1:0] up_v;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_net
            assign down_v[gi]     = q_reg[gi + 1];
            assign up_v[gi + 1]   = q_reg[gi];
        end
    endgenerate
    assign down_v[WIDTH-1] = 1'b0;
    assign up_v[0]         = 1'b0;

    // While running, the captured op repeats and live command inputs are ignored
    assign step_op  = (state_reg == ST_RUN) ? op_reg : bus.op;
    assign is_multi = (bus.op >= OP_SHR) && (bus.op <= OP_ASR);

    // One step of the selected operation; serial inputs are always sampled live
    always_comb begin
        step_q    = q_reg;
        step_sout = sout_reg;
        case (step_op)
            OP_NOP: begin
                step_q = q_reg;
            end
            OP_LOAD: begin
                step_q = bus.d;
            end
            OP_SHR: begin
                step_q           = down_v;
                step_q[WIDTH-1]  = bus.sr_in;
                step_sout        = q_reg[0];
            end
            OP_SHL: begin
                step_q           = up_v;
                step_q[0]        = bus.sl_in;
                step_sout        = q_reg[WIDTH-1];
            end
            OP_ROR: begin
                step_q           = down_v;
                step_q[WIDTH-1]  = q_reg[0];
                step_sout        = q_reg[0];
            end
            OP_ROL: begin
                step_q           = up_v;
                step_q[0]        = q_reg[WIDTH-1];
                step_sout        = q_reg[WIDTH-1];
            end
            OP_ASR: begin
                step_q           = down_v;
                step_q[WIDTH-1]  = q_reg[WIDTH-1];
                step_sout        = q_reg[0];
            end
            OP_CLR: begin
                step_q = '0;
            end
            default: begin
                step_q = q_reg;
            end
        endcase
    end

    // Next-state and datapath control: single steps when idle, counted repeats when running
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        sout_next  = sout_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start && is_multi) begin
                    op_next = bus.op;
                    if (bus.amt == '0) begin
                        // Zero-length command: nothing moves, just acknowledge
                        done_next = 1'b1;
                    end else begin
                        q_next    = step_q;
                        sout_next = step_sout;
                        cnt_next  = bus.amt - AMT_ONE;
                        if (bus.amt == AMT_ONE) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end else begin
                    q_next    = step_q;
                    sout_next = step_sout;
                end
            end
            ST_RUN: begin
                q_next    = step_q;
                sout_next = step_sout;
                if (cnt_reg <= AMT_ONE) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - AMT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation without a done pulse
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= ST_IDLE;
            q_reg     <= '0;
            sout_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            op_reg    <= OP_NOP;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            sout_reg  <= sout_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    assign bus.q    = q_reg;
    assign bus.sout = sout_reg;
    assign bus.busy = (state_reg == ST_RUN);
    assign bus.done = done_reg;
endmodule

// File: tb/tb_shreg_univ.sv
// Scoreboard bench for shreg_univ (WIDTH=8, AMT_W=4).
module tb_shreg_univ;
    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHR  = 3'b010;
    localparam logic [2:0] SHL  = 3'b011;
    localparam logic [2:0] ROR  = 3'b100;
    localparam logic [2:0] ROL  = 3'b101;
    localparam logic [2:0] ASR  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_b;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    exp_t mon_e;

    shreg_univ_if #(.WIDTH(8), .AMT_W(4)) bus ();

    shreg_univ #(.WIDTH(8), .AMT_W(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue its expected result
    task automatic drive(input string tag, input logic [2:0] op, input logic st,
                         input logic [3:0] amt, input logic [7:0] d,
                         input logic sr, input logic sl,
                         input logic [7:0] eq, input logic es,
                         input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        bus.op    = op;
        bus.start = st;
        bus.amt   = amt;
        bus.d     = d;
        bus.sr_in = sr;
        bus.sl_in = sl;
        e.tag  = tag;
        e.q    = eq;
        e.sout = es;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
    endtask

    // Monitor: after each rising edge, pop the oldest expectation and compare
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_eq({mon_e.tag, ".q"},    32'(bus.q),    32'(mon_e.q));
            check_eq({mon_e.tag, ".sout"}, 32'(bus.sout), 32'(mon_e.sout));
            check_eq({mon_e.tag, ".busy"}, 32'(bus.busy), 32'(mon_e.busy));
            check_eq({mon_e.tag, ".done"}, 32'(bus.done), 32'(mon_e.done));
            $display("txn %-12s q=%02h sout=%0b busy=%0b done=%0b", mon_e.tag,
                     bus.q, bus.sout, bus.busy, bus.done);
        end
    end

    logic [7:0] rol_q [0:6];
    logic       rol_s [0:6];

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.op = NOP; bus.start = 1'b0; bus.amt = '0; bus.d = '0;
        bus.sr_in = 1'b0; bus.sl_in = 1'b0;
        rol_q[0] = 8'h78; rol_q[1] = 8'hF0; rol_q[2] = 8'hE1; rol_q[3] = 8'hC3;
        rol_q[4] = 8'h87; rol_q[5] = 8'h0F; rol_q[6] = 8'h1E;
        rol_s[0] = 1'b0;  rol_s[1] = 1'b0;  rol_s[2] = 1'b1;  rol_s[3] = 1'b1;
        rol_s[4] = 1'b1;  rol_s[5] = 1'b1;  rol_s[6] = 1'b0;

        // Asynchronous reset without any clock edge
        rst_b = 1'b1;
        #2 rst_b = 1'b0;
        #1;
        check_eq("rst.q",    32'(bus.q),    32'h00);
        check_eq("rst.sout", 32'(bus.sout), 32'h0);
        check_eq("rst.busy", 32'(bus.busy), 32'h0);
        check_eq("rst.done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;

        // Single-step operations
        drive("load_a5", LOAD, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0, 0);
        drive("shr1",    SHR,  0, 0, 8'h00, 1, 0, 8'hD2, 1, 0, 0);
        drive("shl1",    SHL,  0, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 0);
        drive("nop",     NOP,  0, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 0);

        // SHL by 3
        drive("shl3_s1", SHL,  1, 3, 8'h00, 0, 0, 8'h4A, 1, 1, 0);
        drive("shl3_s2", NOP,  0, 0, 8'h00, 0, 0, 8'h94, 0, 1, 0);
        drive("shl3_s3", NOP,  0, 0, 8'h00, 0, 0, 8'h28, 1, 0, 1);
        drive("shl3_end",NOP,  0, 0, 8'h00, 0, 0, 8'h28, 1, 0, 0);

        // ASR by 4
        drive("load_96", LOAD, 0, 0, 8'h96, 0, 0, 8'h96, 1, 0, 0);
        drive("asr4_s1", ASR,  1, 4, 8'h00, 0, 0, 8'hCB, 0, 1, 0);
        drive("asr4_s2", NOP,  0, 0, 8'h00, 0, 0, 8'hE5, 1, 1, 0);
        drive("asr4_s3", NOP,  0, 0, 8'h00, 0, 0, 8'hF2, 1, 1, 0);
        drive("asr4_s4", NOP,  0, 0, 8'h00, 0, 0, 8'hF9, 0, 0, 1);

        // ROL by WIDTH with LOAD/start attempts while busy, then back-to-back ROR
        drive("load_3c", LOAD, 0, 0, 8'h3C, 0, 0, 8'h3C, 0, 0, 0);
        drive("rol8_s1", ROL,  1, 8, 8'h00, 0, 0, rol_q[0], rol_s[0], 1, 0);
        for (int i = 1; i < 7; i++) begin
            drive($sformatf("rol8_s%0d", i + 1), LOAD, 1, 2, 8'hFF, 1, 1,
                  rol_q[i], rol_s[i], 1, 0);
        end
        drive("rol8_s8", LOAD, 1, 2, 8'hFF, 1, 1, 8'h3C, 0, 0, 1);
        drive("ror1_b2b",ROR,  1, 1, 8'h00, 0, 0, 8'h1E, 0, 0, 1);
        drive("ror1_end",NOP,  0, 0, 8'h00, 0, 0, 8'h1E, 0, 0, 0);

        // Zero-length command
        drive("shr0",    SHR,  1, 0, 8'h00, 1, 0, 8'h1E, 0, 0, 1);
        drive("shr0_end",NOP,  0, 0, 8'h00, 0, 0, 8'h1E, 0, 0, 0);

        // start with a single-cycle op: no handshake
        drive("load_st", LOAD, 1, 3, 8'h5A, 0, 0, 8'h5A, 0, 0, 0);

        // ROR by 5 abandoned by reset after two steps
        drive("ror5_s1", ROR,  1, 5, 8'h00, 0, 0, 8'h2D, 0, 1, 0);
        drive("ror5_s2", NOP,  0, 0, 8'h00, 0, 0, 8'h96, 1, 1, 0);
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        check_eq("midrst.q",    32'(bus.q),    32'h00);
        check_eq("midrst.sout", 32'(bus.sout), 32'h0);
        check_eq("midrst.busy", 32'(bus.busy), 32'h0);
        check_eq("midrst.done", 32'(bus.done), 32'h0);
        #1 rst_b = 1'b1;
        drive("post_rst1",NOP, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        drive("post_rst2",NOP, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

        // Next start after reset behaves normally
        drive("load_81", LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0, 0);
        drive("ror2_s1", ROR,  1, 2, 8'h00, 0, 0, 8'hC0, 1, 1, 0);
        drive("ror2_s2", NOP,  0, 0, 8'h00, 0, 0, 8'h60, 0, 0, 1);
        drive("shr_s1",  SHR,  0, 0, 8'h00, 0, 0, 8'h30, 0, 0, 0);
        drive("ror_s1",  ROR,  0, 0, 8'h00, 0, 0, 8'h18, 0, 0, 0);
        drive("ror_s2",  ROR,  0, 0, 8'h00, 0, 0, 8'h0C, 0, 0, 0);
        drive("ror_s3",  ROR,  0, 0, 8'h00, 0, 0, 8'h06, 0, 0, 0);
        drive("ror_s4",  ROR,  0, 0, 8'h00, 0, 0, 8'h03, 0, 0, 0);
        drive("ror_s5",  ROR,  0, 0, 8'h00, 0, 0, 8'h81, 1, 0, 0);
        drive("clr_st",  CLR,  1, 4, 8'h00, 0, 0, 8'h00, 1, 0, 0);

        drive("idle_end",NOP,  0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        @(posedge clk);
        #2;
        check_eq("sb_drain", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shreg_univ.md
Name: shreg_univ

Overview:
- Parametrised universal shift register; next generation of the 4-bit load/shift-right register.
- Adds width parameter, eight operations (load, logical/arithmetic shifts, rotates, clear), and a multi-cycle "shift by N" command with start/busy/done handshake.
- Used as a datapath operand register and serial converter in lab arithmetic units (multipliers, dividers, serial links).

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- AMT_W, 4, width of shift-amount input; amounts 0..2**AMT_W-1 are legal, including values >= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- op  in  3  operation code, decoded below.
- start  in  1  launch multi-cycle operation of amt steps; sampled only when idle.
- amt  in  AMT_W  step count for start.
- d  in  WIDTH  parallel load data.
- sr_in  in  1  serial input entering the MSB on SHR.
- sl_in  in  1  serial input entering the LSB on SHL.
- q  out  WIDTH  register contents.
- sout  out  1  last bit shifted or rotated out (registered).
- busy  out  1  multi-cycle operation in progress; inputs are ignored.
- done  out  1  one-cycle pulse: multi-cycle operation complete.

Behaviour:
- Reset (async, rst_b=0): q=0, sout=0, busy=0, done=0, internal step counter=0. Takes effect immediately, including mid-operation; the operation is abandoned and no done pulse is issued.
- Op codes, one step each:
  - 000 NOP: hold.
  - 001 LOAD: q<=d.
  - 010 SHR: q<={sr_in,q[W-1:1]}, sout<=q[0].
  - 011 SHL: q<={q[W-2:0],sl_in}, sout<=q[W-1].
  - 100 ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
  - 101 ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
  - 110 ASR: q<={q[W-1],q[W-1:1]}, sout<=q[0].
  - 111 CLR: q<=0, sout unchanged.
- sout changes only on shift or rotate steps (010-110).
- Idle (busy=0) with start=0: op executes once on each rising edge.
- Idle with start=1 and op in 010-110: op and amt are captured.
  - amt=0: q and sout unchanged, busy stays 0, done=1 for the cycle after the edge.
  - amt>=1: first step at the start edge (T); remaining steps at edges T+1 .. T+amt-1.
  - busy=1 after edges T .. T+amt-2 (never set when amt=1).
  - done=1 for exactly one cycle after edge T+amt-1; busy=0 in that same cycle.
- Idle with start=1 and op in {NOP, LOAD, CLR}: op executes as a single cycle; no busy, no done.
- While busy=1: op, start, amt and d are ignored; the captured op repeats. sr_in and sl_in are sampled live on every step.
- A new start is accepted in the same cycle that done=1 (back-to-back).
- Amounts >= WIDTH are not saturated; every step is executed. Example: ROL by WIDTH returns the original value.
- done is a registered output, deasserted on every edge where it is not newly set.
- Step counter is AMT_W bits wide and never wraps: it loads amt-1 and stops at 0.

Test Plan:
- Reset: assert rst_b=0 mid-cycle -> q=8'h00, sout=0, busy=0, done=0 immediately, without a clock edge.
- LOAD 8'hA5, then single SHR with sr_in=1 -> q=8'hD2, sout=1; then SHL with sl_in=1 -> q=8'hA5, sout=1.
- q=8'hA5, start SHL amt=3, sl_in=0 ->
  - busy high for 2 cycles;
  - q=8'h4A, 8'h94, then 8'h28;
  - done pulses once with q=8'h28, sout=1.
- q=8'h96, start ASR amt=4 -> q=8'hF9, sout=0, single done pulse.
- q=8'h3C, start ROL amt=8, drive LOAD d=8'hFF while busy ->
  - LOAD ignored;
  - final q=8'h3C, done after the 8th edge;
  - new start ROR amt=1 issued in the done cycle is accepted: q=8'h1E, done on the next cycle.
- Boundary cases:
  - start SHR amt=0 -> q unchanged, busy never high, done one cycle later.
  - start ROR amt=5 with rst_b pulsed low after 2 steps -> q=0, busy=0, no done; the next start is accepted normally.
